// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and load-unit writebacks onto the single register-file write port and keeps a busy scoreboard.
// Optional RF_WB_BYPASS_EN: rsK_busy is masked for a register being written in the current cycle.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [AW-1:0]   rd0,
  input  logic [XLEN-1:0] data0,
  output logic            gnt0,
  input  logic            req1,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] data1,
  output logic            gnt1,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic            resv_valid,
  input  logic [AW-1:0]   resv_rd,
  output logic            resv_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            idle
);

  localparam int unsigned NREG = 2 ** AW;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            last_gnt;
  logic            resv_accept;

  // last_gnt = 1 means requester 1 won last, so requester 0 wins the next conflict
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      gnt0 = req0 & (~req1 | last_gnt);
      gnt1 = req1 & (~req0 | ~last_gnt);
    end
  end

  assign resv_ready  = (resv_rd == '0) | ~busy[resv_rd];
  assign resv_accept = resv_valid & resv_ready & (resv_rd != '0);

  // Clear is applied before set so a same-edge set of the same index wins
  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[wr_addr] = 1'b0;
    if (resv_accept)
      busy_nxt[resv_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      last_gnt <= 1'b1;
    end else begin
      busy  <= busy_nxt;
      wr_en <= 1'b0;
      if (gnt0) begin
        last_gnt <= 1'b0;
        if (rd0 != '0) begin
          wr_en   <= 1'b1;
          wr_addr <= rd0;
          wr_data <= data0;
        end
      end else if (gnt1) begin
        last_gnt <= 1'b1;
        if (rd1 != '0) begin
          wr_en   <= 1'b1;
          wr_addr <= rd1;
          wr_data <= data1;
        end
      end
    end
  end

  always_comb begin
    rs1_busy = (rs1_addr != '0) & busy[rs1_addr];
    rs2_busy = (rs2_addr != '0) & busy[rs2_addr];
`ifdef RF_WB_BYPASS_EN
    if (wr_en && (wr_addr == rs1_addr))
      rs1_busy = 1'b0;
    if (wr_en && (wr_addr == rs2_addr))
      rs2_busy = 1'b0;
`endif
  end

  assign idle = (busy == '0) & ~wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; honours RF_WB_BYPASS_EN for the commit-cycle hazard value.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

`ifdef RF_WB_BYPASS_EN
  localparam logic COMMIT_BUSY = 1'b0;
`else
  localparam logic COMMIT_BUSY = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, req1, resv_valid;
  logic [AW-1:0]   rd0, rd1, resv_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] data0, data1;
  logic            gnt0, gnt1, wr_en, resv_ready, rs1_busy, rs2_busy, idle;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rd0(rd0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .rd1(rd1), .data1(data1), .gnt1(gnt1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_valid(resv_valid), .resv_rd(resv_rd), .resv_ready(resv_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; rd0 = 5'd2; data0 = 32'h1;
    settle();
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", idle); end
    req0 = 1'b0;
    rst = 1'b1;
    settle();
  endtask

  task automatic test_single_write();
    resv_valid = 1'b1; resv_rd = 5'd5;
    settle();
    n_cmp++; if (resv_ready !== 1'b1) begin n_err++; $display("FAIL single_resv_ready got=%b exp=1", resv_ready); end
    step();
    resv_valid = 1'b0; rs1_addr = 5'd5;
    req0 = 1'b1; rd0 = 5'd5; data0 = 32'hDEADBEEF;
    settle();
    n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL single_rs1_busy got=%b exp=1", rs1_busy); end
    n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_err++; $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1}); end
    step();
    req0 = 1'b0;
    settle();
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
    n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_wr_addr got=%0d exp=5", wr_addr); end
    n_cmp++; if (wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_after got=%b exp=0", wr_en); end
    n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_cleared got=%b exp=0", rs1_busy); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] exp_addr [4];
    logic [1:0]    exp_gnt  [4];
    exp_addr[0] = 5'd3; exp_addr[1] = 5'd4; exp_addr[2] = 5'd3; exp_addr[3] = 5'd4;
    exp_gnt[0]  = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    rst = 1'b0;
    step();
    rst = 1'b1;
    req0 = 1'b1; rd0 = 5'd3; data0 = 32'hA0A0_0003;
    req1 = 1'b1; rd1 = 5'd4; data1 = 32'hB1B1_0004;
    settle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({gnt0, gnt1} !== exp_gnt[i]) begin n_err++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, {gnt0, gnt1}, exp_gnt[i]); end
      if (i > 0) begin
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== exp_addr[i-1]) begin n_err++; $display("FAIL alt_wr[%0d] got=%b/%0d exp=1/%0d", i-1, wr_en, wr_addr, exp_addr[i-1]); end
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    settle();
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'hB1B1_0004) begin n_err++; $display("FAIL alt_wr[3] got=%b/%0d/%h exp=1/4/b1b10004", wr_en, wr_addr, wr_data); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL alt_wr_en_done got=%b exp=0", wr_en); end
  endtask

  task automatic test_hazard();
    resv_valid = 1'b1; resv_rd = 5'd7;
    step();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    settle();
    n_cmp++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin n_err++; $display("FAIL hz_busy got=%b%b exp=11", rs1_busy, rs2_busy); end
    n_cmp++; if (resv_ready !== 1'b0) begin n_err++; $display("FAIL hz_resv_again got=%b exp=0", resv_ready); end
    step();
    resv_valid = 1'b0;
    req1 = 1'b1; rd1 = 5'd7; data1 = 32'h0000_0777;
    settle();
    n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL hz_busy_hold got=%b exp=1", rs1_busy); end
    n_cmp++; if ({gnt0, gnt1} !== 2'b01) begin n_err++; $display("FAIL hz_gnt got=%b exp=01", {gnt0, gnt1}); end
    step();
    req1 = 1'b0;
    settle();
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin n_err++; $display("FAIL hz_commit got=%b/%0d exp=1/7", wr_en, wr_addr); end
    n_cmp++; if (rs1_busy !== COMMIT_BUSY || rs2_busy !== COMMIT_BUSY) begin n_err++; $display("FAIL hz_commit_busy got=%b%b exp=%b%b", rs1_busy, rs2_busy, COMMIT_BUSY, COMMIT_BUSY); end
    step();
    n_cmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL hz_after got=%b%b exp=00", rs1_busy, rs2_busy); end
  endtask

  task automatic test_rd_zero();
    req1 = 1'b1; rd1 = 5'd0; data1 = 32'h1234; rs1_addr = 5'd0;
    settle();
    n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL rd0_gnt1 got=%b exp=1", gnt1); end
    step();
    req1 = 1'b0;
    settle();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rd0_wr_en got=%b exp=0", wr_en); end
    n_cmp++; if (rs1_busy !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL rd0_state got=%b/%b exp=0/1", rs1_busy, idle); end
    resv_valid = 1'b1; resv_rd = 5'd0;
    settle();
    n_cmp++; if (resv_ready !== 1'b1) begin n_err++; $display("FAIL rd0_resv_ready got=%b exp=1", resv_ready); end
    step();
    resv_valid = 1'b0;
    settle();
    n_cmp++; if (idle !== 1'b1 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL rd0_resv_nochange got=%b/%b exp=1/0", idle, rs1_busy); end
  endtask

  task automatic test_set_wins();
    req0 = 1'b1; rd0 = 5'd9; data0 = 32'h9999;
    step();
    req0 = 1'b0;
    resv_valid = 1'b1; resv_rd = 5'd9;
    settle();
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd9) begin n_err++; $display("FAIL sw_commit got=%b/%0d exp=1/9", wr_en, wr_addr); end
    n_cmp++; if (resv_ready !== 1'b1) begin n_err++; $display("FAIL sw_resv_ready got=%b exp=1", resv_ready); end
    step();
    resv_valid = 1'b0; rs1_addr = 5'd9;
    settle();
    n_cmp++; if (rs1_busy !== 1'b1 || idle !== 1'b0) begin n_err++; $display("FAIL sw_busy9 got=%b/%b exp=1/0", rs1_busy, idle); end
  endtask

  task automatic test_reset_pending();
    req0 = 1'b1; rd0 = 5'd9; data0 = 32'h5555; rst = 1'b0;
    settle();
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL rp_gnt0 got=%b exp=0", gnt0); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rp_wr_en got=%b exp=0", wr_en); end
    n_cmp++; if (rs1_busy !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL rp_busy_clear got=%b/%b exp=0/1", rs1_busy, idle); end
    req0 = 1'b0;
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; resv_valid = 1'b0;
    rd0 = '0; rd1 = '0; resv_rd = '0; rs1_addr = '0; rs2_addr = '0;
    data0 = '0; data1 = '0;
    test_reset();
    test_single_write();
    test_alternate();
    test_hazard();
    test_rd_zero();
    test_set_wins();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback, requester 1 is load-unit writeback.
- Tracks in-flight destination registers in a busy scoreboard and tells decode when rs1/rs2 are still waiting on a write.
- Drives the register file's writeControl, Rd_addr and Write_Rd_data from registered outputs.

Parameters:
XLEN, 32, data width of the register file
AW, 5, register address width (2^AW registers; x0 hardwired zero)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-low reset (0 = reset)
req0  input  1  requester 0 write request
rd0  input  AW  requester 0 destination register
data0  input  XLEN  requester 0 write data
gnt0  output  1  requester 0 grant (combinational)
req1  input  1  requester 1 write request
rd1  input  AW  requester 1 destination register
data1  input  XLEN  requester 1 write data
gnt1  output  1  requester 1 grant (combinational)
wr_en  output  1  to register file writeControl
wr_addr  output  AW  to register file Rd_addr
wr_data  output  XLEN  to register file Write_Rd_data
resv_valid  input  1  decode reserves a destination register
resv_rd  input  AW  register to reserve
resv_ready  output  1  reservation can be accepted
rs1_addr  input  AW  decode source 1
rs2_addr  input  AW  decode source 2
rs1_busy  output  1  rs1 has a pending write
rs2_busy  output  1  rs2 has a pending write
idle  output  1  no busy register and no write in flight

Behaviour:
- Reset: sampled only on a clk edge with rst=0.
  - Clears busy[], wr_en=0, wr_addr=0, wr_data=0.
  - Sets last_gnt=1, so requester 0 wins the first conflict.
  - Any grant in that cycle is discarded.
  - gnt0/gnt1=0 while rst=0.
- Handshake:
  - A transfer occurs when reqN & gntN.
  - A requester holds reqN/rdN/dataN stable until granted.
  - At most one grant per cycle.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: grant goes to the one not in last_gnt.
  - last_gnt updates only on a transfer.
- Latency: a transfer at edge N appears on wr_en/wr_addr/wr_data during cycle N+1, exactly one cycle. wr_en=0 when there is no transfer.
- rd=0 transfers: granted and consumed, but wr_en stays 0 and the scoreboard is untouched.
- Scoreboard busy[2^AW] (busy[0] always 0):
  - Set: resv_valid & resv_ready & resv_rd!=0 sets busy[resv_rd].
  - resv_ready = (resv_rd==0) | ~busy[resv_rd]. This enforces one outstanding write per register (no WAW).
  - Clear: busy[wr_addr] is cleared on the edge ending the cycle where wr_en=1.
  - Same-edge set and clear of the same index: set wins, busy stays 1.
- Hazards:
  - rsK_busy = (rsK_addr!=0) & busy[rsK_addr], combinational.
  - This is without bypass; see Optional Feature.
- idle = (busy==0) & ~wr_en.
- Writes to a non-busy register (not reserved) are still performed. The scoreboard clear is a no-op in that case.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - rsK_busy is additionally masked when wr_en=1 and wr_addr==rsK_addr.
  - Same-cycle writes are assumed to be visible through the register file, so decode may proceed in the commit cycle.
- Undefined:
  - rsK_busy stays 1 through the commit cycle and drops the cycle after.
  - This costs one extra stall cycle per dependent instruction.

Test Plan:
- Reset, then reserve x5, then req0 rd0=5 data0=0xDEADBEEF.
  - Required: gnt0=1 the same cycle.
  - Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
  - Following cycle: busy[5]=0 and idle=1.
- req0 and req1 held for 4 cycles, rd0=3 and rd1=4, data held stable.
  - Required: grants alternate 0,1,0,1 starting with 0.
  - wr_addr sequence: 3,4,3,4, each one cycle late.
- Reserve x7 with rs1_addr=7 (x7 busy).
  - Required: rs1_busy=1 until the commit. With the macro undefined, it drops the cycle after wr_en; with the macro defined, it drops in the commit cycle.
  - A second reservation of x7 while busy gives resv_ready=0.
- req1 with rd1=0 and data1=0x1234.
  - Required: gnt1=1, wr_en stays 0, busy[0]=0.
  - Reserving x0 gives resv_ready=1 with no state change.
- Commit to x9 in the same cycle as a new reservation of x9.
  - Required: busy[9]=1 afterward.
  - rst=0 asserted while req0 is pending: the next cycle has wr_en=0, all busy bits 0, and gnt0=0 during reset.
